// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/ready/done handshake for the decimal display path.
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Reset_b,
  input  logic                  start,
  input  logic [WIDTH-1:0]      data_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              overflow_q, overflow_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     step_scratch;
  logic              step_ovf;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;

    // Per-digit +3 correction, no carry between digits
    adj = scratch_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
    end
    // Bit leaving the top digit is a carry into 10^DIGITS
    step_scratch = {adj[BW-2:0], shift_q[WIDTH-1]};
    step_ovf     = ovf_q | adj[BW-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CONV;
          shift_d   = data_in;
          scratch_d = '0;
          ovf_d     = 1'b0;
          count_d   = CW'(WIDTH);
        end
      end
      S_CONV: begin
        shift_d   = shift_q << 1;
        scratch_d = step_scratch;
        ovf_d     = step_ovf;
        count_d   = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d    = S_DONE;
          bcd_d      = step_scratch;
          overflow_d = step_ovf;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_CONV);
  assign done     = (state_q == S_DONE);
  assign bcd_out  = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed, table-driven bench for result_bcd_converter (3-digit and 2-digit builds).
module tb_result_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start3, start2;
  logic [7:0]  data;
  logic        ready3, busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        ready2, busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int cmp_count = 0;
  int err_count = 0;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut3 (
    .Clock(clk), .Reset_b(rst_n), .start(start3), .data_in(data),
    .ready(ready3), .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  result_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .Clock(clk), .Reset_b(rst_n), .start(start2), .data_in(data),
    .ready(ready2), .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          d2;
    logic [7:0]  val;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion on the selected instance; checks latency, result, and return to IDLE.
  task automatic run_vec(input bit d2, input logic [7:0] val, input logic [11:0] exp_bcd,
                         input logic exp_ovf, input string name);
    int k;
    logic d_done;
    @(negedge clk);
    data = val;
    if (d2) start2 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    start2 = 1'b0;
    check({name, "_busy"}, d2 ? busy2 : busy3, 1);
    check({name, "_ready"}, d2 ? ready2 : ready3, 0);
    k = 1;
    while (k <= 20) begin
      @(negedge clk);
      d_done = d2 ? done2 : done3;
      if (d_done) break;
      k++;
    end
    check({name, "_latency"}, k, 8);
    check({name, "_bcd"}, d2 ? {4'h0, bcd2} : bcd3, exp_bcd);
    check({name, "_ovf"}, d2 ? ovf2 : ovf3, exp_ovf);
    @(negedge clk);
    check({name, "_ready_after"}, d2 ? ready2 : ready3, 1);
    check({name, "_done_after"}, d2 ? done2 : done3, 0);
  endtask

  initial begin
    int n_done;
    rst_n  = 1'b0;
    start3 = 1'b0;
    start2 = 1'b0;
    data   = 8'd0;

    vecs[0]  = '{0, 8'd0,   12'h000, 1'b0};
    vecs[1]  = '{0, 8'd255, 12'h255, 1'b0};
    vecs[2]  = '{0, 8'd99,  12'h099, 1'b0};
    vecs[3]  = '{0, 8'd10,  12'h010, 1'b0};
    vecs[4]  = '{0, 8'd128, 12'h128, 1'b0};
    vecs[5]  = '{0, 8'd1,   12'h001, 1'b0};
    vecs[6]  = '{1, 8'd200, 12'h000, 1'b1};
    vecs[7]  = '{1, 8'd123, 12'h023, 1'b1};
    vecs[8]  = '{1, 8'd99,  12'h099, 1'b0};
    vecs[9]  = '{1, 8'd100, 12'h000, 1'b1};
    vecs[10] = '{1, 8'd199, 12'h099, 1'b1};
    vecs[11] = '{0, 8'd59,  12'h059, 1'b0};

    #12;
    check("rst_ready", ready3, 1);
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_bcd", bcd3, 0);
    check("rst_ovf", ovf3, 0);
    check("rst_ready2", ready2, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].d2, vecs[i].val, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // start/data_in hammered during CONV and DONE must be ignored
    @(negedge clk);
    data = 8'd37;
    start3 = 1'b1;
    @(negedge clk);
    data = 8'd200;
    n_done = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done3) n_done++;
      if (k == 8) check("ign_bcd_at_done", bcd3, 12'h037);
      if (k < 9) check($sformatf("ign_ready_k%0d", k), ready3, 0);
    end
    start3 = 1'b0;
    check("ign_done_count", n_done, 1);
    check("ign_ready_idle", ready3, 1);
    @(negedge clk);
    check("ign_no_restart", busy3, 0);
    check("ign_bcd_hold", bcd3, 12'h037);

    // Asynchronous reset four edges into a conversion
    @(negedge clk);
    data = 8'd77;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy3, 0);
    check("arst_ready", ready3, 1);
    check("arst_bcd", bcd3, 0);
    check("arst_ovf", ovf3, 0);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done3) n_done++;
    end
    check("arst_no_done", n_done, 0);
    rst_n = 1'b1;
    run_vec(0, 8'd128, 12'h128, 1'b0, "post_rst");

    // start held high: one conversion every WIDTH+2 cycles
    @(negedge clk);
    data = 8'd1;
    start3 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("held_done_k%0d", k), done3, (k % 10) == 8);
      check($sformatf("held_ready_k%0d", k), ready3, (k % 10) == 9);
      if ((k % 10) == 8) check($sformatf("held_bcd_k%0d", k), bcd3, 12'h001);
      if (k < 39) @(negedge clk);
    end
    start3 = 1'b0;
    @(negedge clk);
    check("held_stop", ready3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
